vram_fill_arbiter: RTL and testbench
====================================

# vram_fill_arbiter

Shares the VRAM system port between the Hack CPU and a hardware fill engine that writes one 16-bit pattern across a contiguous word range, e.g. a clear-screen in 8192 accepted writes instead of a CPU loop. Sits between the CPU memory-map decode and the Screen block's `vram_load`/`vram_addr`/`vram_din`/`vram_busy`/`vram_dout` port. VGA pixel fetch keeps its own priority inside VRAM and is visible here only through `vram_busy`.

## Interface
- `ADDR_W`, 13: VRAM word address width.
- `FILL_WORDS`, 8192: words written per fill; range 1..2^ADDR_W.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU is accessing VRAM this cycle (read or write).
- `cpu_load` in 1: CPU write strobe; qualified by `cpu_req`.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_din` in 16: CPU write data.
- `cpu_dout` out 16: read data; wired directly to `vram_dout`.
- `cpu_busy` out 1: CPU access not accepted this cycle; CPU holds its request.
- `fill_start` in 1: one-cycle pulse; starts a fill from word 0.
- `fill_pattern` in 16: fill data; sampled on the accepted `fill_start`.
- `fill_busy` out 1: fill in progress.
- `fill_done` out 1: one-cycle pulse after the last fill write is accepted.
- `vram_load` out 1, `vram_addr` out ADDR_W, `vram_din` out 16: to the VRAM system port.
- `vram_busy` in 1: VRAM rejects the system access this cycle.
- `vram_dout` in 16: VRAM system read data.

## Operation
- FSM states: IDLE, FILL. Registers: `cnt` (ADDR_W+1 bits), `pat` (16), `done_r`.
- IDLE: `fill_start`=1 sets `pat`←`fill_pattern`, `cnt`←0, next state FILL.
- FILL: `fill_start` is ignored; `pat` does not change.
- Grant, computed combinationally each cycle: CPU wins if `cpu_req`=1; otherwise fill wins if state is FILL.
- CPU granted: `vram_addr`=`cpu_addr`, `vram_din`=`cpu_din`, `vram_load`=`cpu_load`, `cpu_busy`=`vram_busy`.
- Fill granted: `vram_addr`=`cnt[ADDR_W-1:0]`, `vram_din`=`pat`, `vram_load`=1, `cpu_busy`=0.
- No grant: `vram_load`=0, `vram_addr`=`cpu_addr`, `vram_din`=`cpu_din`.
- A fill write is accepted when fill holds the grant and `vram_busy`=0. On acceptance, `cnt` increments.
- The acceptance with `cnt`=`FILL_WORDS`-1 ends the fill: next state IDLE, `done_r`←1 for exactly one cycle.
- A fill write rejected by `vram_busy` is retried at the same address. No address is skipped or written twice.
- CPU writes during a fill land normally. A later fill write to the same address overwrites them; this is intended.

## Timing
- Reset values (cycle after `reset` is sampled high): state IDLE, `cnt`=0, `pat`=0, `fill_busy`=0, `fill_done`=0.
- While `reset`=1, the VRAM-side outputs follow the CPU path and fill never holds the grant.
- Reset in the middle of a fill aborts it: state IDLE, and `fill_done` does not pulse.
- `fill_start` while `reset`=1 is ignored.
- `fill_busy` rises in the cycle after `fill_start`, so the first fill write can issue one cycle after the start.
- `fill_done` is asserted in the cycle after the last acceptance, in the same cycle `fill_busy` falls.
- A `fill_start` in the `fill_done` cycle is accepted and starts a new fill.
- Minimum fill duration is `FILL_WORDS` cycles, reached when `cpu_req`=0 and `vram_busy`=0 throughout.
- `cpu_dout`, `cpu_busy` and all VRAM-side outputs are combinational from registered state and current inputs. The CPU path adds zero latency.

## Configuration
- `VRAM_ARB_FAIR_EN` defined: a 4-bit `starve` counter counts consecutive FILL cycles in which fill lost the grant to `cpu_req`.
  - At `starve`=15, the next cycle grants fill even with `cpu_req`=1.
  - In that cycle `cpu_busy`=1 and `starve` clears.
  - `starve` also clears on any fill grant and in IDLE.
  - This bounds fill starvation to 16 cycles.
- `VRAM_ARB_FAIR_EN` undefined: strict CPU priority. No `starve` register. `cpu_busy` equals `vram_busy` whenever `cpu_req`=1.

## Test plan
- Reset, then `fill_start` with `fill_pattern`=16'hA5A5, `FILL_WORDS`=8192, `cpu_req`=0, `vram_busy`=0 → addresses 0..8191 each written once with A5A5; `fill_done` pulses exactly 8193 cycles after the start cycle.
- During a fill, `vram_busy` high for 3 cycles at `cnt`=100 → address 100 is held for 3 cycles then written once; total duration grows by 3.
- During a fill, `cpu_req`=1 with `cpu_load`=1, `cpu_addr`=5 for 20 cycles → CPU write lands and `cpu_busy`=0. Without `VRAM_ARB_FAIR_EN`, fill stalls all 20 cycles. With it, fill gets cycle 16 and `cpu_busy`=1 in that cycle only.
- `reset` pulsed at `cnt`=4000 → `fill_busy`=0 and no `fill_done`. A new `fill_start` restarts from address 0.
- `fill_start` with pattern 16'h1234 while filling → ignored; the pattern stays unchanged and the address sequence is unaffected.
- `fill_start` in the `fill_done` cycle with pattern 16'h0000 → a second fill starts with no gap and writes 0000.

Source files
------------

// File: rtl/vram_fill_arbiter.sv
//------------------------------------------------------------------------------
// vram_fill_arbiter
//
// Shares the VRAM system port between the Hack CPU and a hardware fill engine.
// The fill engine writes one 16-bit pattern to VRAM words 0..FILL_WORDS-1
// (for example a clear-screen) while the CPU keeps normal access to VRAM.
// The VGA pixel fetch arbitrates inside VRAM. This block sees it only through
// vram_busy.
//
// Arbitration: the CPU wins whenever cpu_req is high. The fill engine uses
// every cycle the CPU leaves idle. A fill write that vram_busy rejects is
// retried at the same address. No word is skipped or written twice.
//
// Optional feature (compile-time macro VRAM_ARB_FAIR_EN):
//   When the macro is defined, a 4-bit starvation counter tracks consecutive
//   fill cycles lost to the CPU. After 15 such cycles the fill engine takes
//   the next cycle and the CPU sees cpu_busy. A fill therefore waits at most
//   16 cycles for the port. When the macro is undefined, the CPU has strict
//   priority.
//
// Parameters:
//   ADDR_W       VRAM word address width
//   FILL_WORDS   words written per fill (1..2**ADDR_W)
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   cpu_req/cpu_load        CPU access this cycle / write strobe
//   cpu_addr/cpu_din        CPU word address / write data
//   cpu_dout                CPU read data (direct from vram_dout)
//   cpu_busy                CPU access not accepted this cycle
//   fill_start              one-cycle pulse that starts a fill at word 0
//   fill_pattern            fill data, captured on an accepted fill_start
//   fill_busy               fill in progress
//   fill_done               one-cycle pulse after the last fill write
//   vram_load/addr/din      VRAM system port request
//   vram_busy               VRAM rejects the system access this cycle
//   vram_dout               VRAM system read data
//------------------------------------------------------------------------------
module vram_fill_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int FILL_WORDS = 8192
) (
  input  logic              clk,
  input  logic              reset,
  // CPU side
  input  logic              cpu_req,
  input  logic              cpu_load,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  output logic              cpu_busy,
  // fill control
  input  logic              fill_start,
  input  logic [15:0]       fill_pattern,
  output logic              fill_busy,
  output logic              fill_done,
  // VRAM system port
  output logic              vram_load,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [15:0]       vram_din,
  input  logic              vram_busy,
  input  logic [15:0]       vram_dout
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  // cnt holds one bit more than the address so that FILL_WORDS = 2**ADDR_W
  // can be represented.
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(FILL_WORDS - 1);

  logic [0:0]      state_q, state_d;
  logic [ADDR_W:0] cnt_q,   cnt_d;
  logic [15:0]     pat_q,   pat_d;
  logic            done_q,  done_d;

  logic in_fill;      // fill may compete for the port this cycle
  logic force_fill;   // anti-starvation override of the CPU
  logic cpu_grant;
  logic fill_grant;
  logic fill_accept;  // fill write taken by VRAM this cycle

  // While reset is asserted the fill engine must not touch VRAM, even though
  // state_q may still read FILL until the reset edge.
  assign in_fill = (state_q == ST_FILL) && !reset;

`ifdef VRAM_ARB_FAIR_EN
  logic [3:0] starve_q, starve_d;

  assign force_fill = in_fill && (starve_q == 4'd15);
`else
  assign force_fill = 1'b0;
`endif

  assign cpu_grant   = cpu_req && !force_fill;
  assign fill_grant  = in_fill && (!cpu_req || force_fill);
  assign fill_accept = fill_grant && !vram_busy;

  //----------------------------------------------------------------------------
  // Port mux. The path is purely combinational, so CPU accesses see no added
  // latency.
  //----------------------------------------------------------------------------
  assign cpu_dout = vram_dout;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first.
    // A path that leaves a signal unassigned would infer a latch.
    vram_addr = cpu_addr;
    vram_din  = cpu_din;
    vram_load = cpu_grant && cpu_load;
    if (fill_grant) begin
      vram_addr = cnt_q[ADDR_W-1:0];
      vram_din  = pat_q;
      vram_load = 1'b1;
    end
    // A CPU request stalls when VRAM refuses it or when fill takes an
    // anti-starvation cycle.
    cpu_busy = cpu_req && (force_fill || vram_busy);
  end

  //----------------------------------------------------------------------------
  // Fill sequencer
  //----------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          pat_d   = fill_pattern;
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        // A fill_start during a fill is ignored. The pattern and the address
        // sequence are not affected.
        if (fill_accept) begin
          cnt_d = cnt_q + (ADDR_W+1)'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef VRAM_ARB_FAIR_EN
  // Counts consecutive fill cycles lost to the CPU. starve_q never goes past
  // 15, because at 15 the fill engine wins the cycle and the count clears.
  always_comb begin
    starve_d = starve_q;
    if (!in_fill || fill_grant) begin
      starve_d = '0;
    end else if (cpu_req) begin
      starve_d = starve_q + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment (<=). All flops then
    // update together from values sampled before the clock edge.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
    end
  end

`ifdef VRAM_ARB_FAIR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // fill_done goes high in the same cycle that fill_busy falls.
  assign fill_busy = (state_q == ST_FILL);
  assign fill_done = done_q;

endmodule

// File: tb/tb_vram_fill_arbiter.sv
//------------------------------------------------------------------------------
// tb_vram_fill_arbiter
//
// Directed bench for vram_fill_arbiter using the default parameters
// (ADDR_W=13, FILL_WORDS=8192). A small VRAM model records the last data
// written to each word and the number of accepted writes to it. Expected
// cycle positions and durations are worked out by hand below.
// Build with +define+VRAM_ARB_FAIR_EN to check the fair-arbitration variant.
//------------------------------------------------------------------------------
module tb_vram_fill_arbiter;

  localparam int ADDR_W     = 13;
  localparam int FILL_WORDS = 8192;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic              cpu_load;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_din;
  logic [15:0]       cpu_dout;
  logic              cpu_busy;
  logic              fill_start;
  logic [15:0]       fill_pattern;
  logic              fill_busy;
  logic              fill_done;
  logic              vram_load;
  logic [ADDR_W-1:0] vram_addr;
  logic [15:0]       vram_din;
  logic              vram_busy;
  logic [15:0]       vram_dout;

  always #5 clk = ~clk;

  vram_fill_arbiter #(
    .ADDR_W     (ADDR_W),
    .FILL_WORDS (FILL_WORDS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_load     (cpu_load),
    .cpu_addr     (cpu_addr),
    .cpu_din      (cpu_din),
    .cpu_dout     (cpu_dout),
    .cpu_busy     (cpu_busy),
    .fill_start   (fill_start),
    .fill_pattern (fill_pattern),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .vram_load    (vram_load),
    .vram_addr    (vram_addr),
    .vram_din     (vram_din),
    .vram_busy    (vram_busy),
    .vram_dout    (vram_dout)
  );

  // VRAM model: one entry per word, plus a count of accepted writes.
  logic [15:0] mem    [FILL_WORDS];
  int          wcount [FILL_WORDS];
  logic        clr_mem = 1'b0;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < FILL_WORDS; i++) begin
        mem[i]    <= 16'hDEAD;
        wcount[i] <= 0;
      end
    end else if (vram_load && !vram_busy) begin
      mem[vram_addr]    <= vram_din;
      wcount[vram_addr] <= wcount[vram_addr] + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of words whose content or write count is wrong.
  // Every word must hold pat and be written exactly once. The only exception
  // is sp_addr (-1 for none), which must hold sp_pat with sp_cnt writes.
  function automatic int count_bad(input logic [15:0] pat, input int sp_addr,
                                   input logic [15:0] sp_pat, input int sp_cnt);
    int bad = 0;
    for (int i = 0; i < FILL_WORDS; i++) begin
      if (i == sp_addr) begin
        if (mem[i] !== sp_pat || wcount[i] != sp_cnt) bad++;
      end else if (mem[i] !== pat || wcount[i] != 1) begin
        bad++;
      end
    end
    return bad;
  endfunction

`ifdef VRAM_ARB_FAIR_EN
  localparam int CPU_STALL  = 19;  // fill takes 1 of the 20 CPU cycles
`else
  localparam int CPU_STALL  = 20;  // fill stalls for the whole CPU burst
`endif

  initial begin
    int done_n;
    int pulses;

    // ---------------- reset behaviour ----------------
    reset        = 1'b1;
    cpu_req      = 1'b1;
    cpu_load     = 1'b1;
    cpu_addr     = 13'd7;
    cpu_din      = 16'h1357;
    fill_start   = 1'b1;  // must be ignored while reset is high
    fill_pattern = 16'h7777;
    vram_busy    = 1'b0;
    vram_dout    = 16'hCAFE;
    tick();
    tick();
    @(negedge clk);
    check("rst_vram_addr", vram_addr, 7);
    check("rst_vram_din",  vram_din,  16'h1357);
    check("rst_vram_load", vram_load, 1);
    check("rst_fill_busy", fill_busy, 0);
    check("rst_fill_done", fill_done, 0);
    check("cpu_dout_pass", cpu_dout,  16'hCAFE);
    vram_busy = 1'b1;
    #1;
    check("rst_cpu_busy",  cpu_busy,  1);
    vram_busy = 1'b0;
    tick();
    reset      = 1'b0;
    fill_start = 1'b0;
    cpu_req    = 1'b0;
    cpu_load   = 1'b0;
    tick();
    @(negedge clk);
    check("rst_start_ignored", fill_busy, 0);
    check("idle_vram_load",    vram_load, 0);

    // ---------------- fill A: plain A5A5 ----------------
    clr_mem = 1'b1;
    tick();
    clr_mem      = 1'b0;
    fill_start   = 1'b1;
    fill_pattern = 16'hA5A5;
    tick();                      // the start cycle is sampled at this edge
    fill_start   = 1'b0;
    fill_pattern = 16'h0F0F;     // a later change must not matter
    done_n = 0;
    for (int n = 1; n <= 9000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("A_busy_rise",  fill_busy, 1);
        check("A_first_addr", vram_addr, 0);
        check("A_first_din",  vram_din,  16'hA5A5);
        check("A_first_load", vram_load, 1);
      end
      if (fill_done) begin
        done_n = n;
        break;
      end
      tick();
    end
    check("A_duration",  done_n,    8193);
    check("A_busy_fall", fill_busy, 0);
    check("A_mem",       count_bad(16'hA5A5, -1, 16'h0, 0), 0);

    // ---------------- fill B: started in A's done cycle ----------------
    clr_mem      = 1'b1;
    fill_start   = 1'b1;
    fill_pattern = 16'h0000;
    tick();
    clr_mem    = 1'b0;
    done_n = 0;
    for (int n = 1; n <= 9000; n++) begin
      vram_busy    = (n >= 101 && n <= 103);
      fill_start   = (n == 200);
      fill_pattern = (n == 200) ? 16'h1234 : 16'hFFFF;
      cpu_req      = (n >= 300 && n <= 319);
      cpu_load     = cpu_req;
      cpu_addr     = 13'd5;
      cpu_din      = 16'hBEEF;
      @(negedge clk);
      if (n == 1) begin
        check("B_done_one_cycle", fill_done, 0);
        check("B_no_gap_busy",    fill_busy, 1);
        check("B_first_addr",     vram_addr, 0);
        check("B_first_din",      vram_din,  16'h0000);
      end
      if (n == 101) check("B_stall_addr0",   vram_addr, 100);
      if (n == 103) check("B_stall_addr2",   vram_addr, 100);
      if (n == 104) check("B_retry_addr",    vram_addr, 100);
      if (n == 105) check("B_after_retry",   vram_addr, 101);
      if (n == 201) begin
        check("B_ignore_start_din",  vram_din,  16'h0000);
        check("B_ignore_start_addr", vram_addr, 197);
      end
      if (n == 300) begin
        check("B_cpu_addr", vram_addr, 5);
        check("B_cpu_din",  vram_din,  16'hBEEF);
        check("B_cpu_load", vram_load, 1);
        check("B_cpu_busy", cpu_busy,  0);
      end
      if (n == 315) begin
`ifdef VRAM_ARB_FAIR_EN
        check("B_fair_addr",     vram_addr, 296);
        check("B_fair_din",      vram_din,  16'h0000);
        check("B_fair_cpu_busy", cpu_busy,  1);
`else
        check("B_strict_addr",     vram_addr, 5);
        check("B_strict_cpu_busy", cpu_busy,  0);
`endif
      end
      if (n == 316) check("B_cpu_busy_after", cpu_busy, 0);
      if (n == 320) check("B_resume_addr", vram_addr, 316 - CPU_STALL);
      if (fill_done) begin
        done_n = n;
        break;
      end
      tick();
    end
    vram_busy  = 1'b0;
    fill_start = 1'b0;
    cpu_req    = 1'b0;
    cpu_load   = 1'b0;
    check("B_duration", done_n, 8193 + 3 + CPU_STALL);
    check("B_mem", count_bad(16'h0000, 5, 16'hBEEF, 1 + CPU_STALL), 0);
    tick();
    @(negedge clk);
    check("B_done_pulse_end", fill_done, 0);
    check("B_idle_busy",      fill_busy, 0);

    // ---------------- fill C: aborted by reset at cnt=4000 ----------------
    fill_start   = 1'b1;
    fill_pattern = 16'h5A5A;
    cpu_addr     = 13'd9;
    tick();
    fill_start = 1'b0;
    repeat (4000) tick();        // now in cycle 4001, cnt = 4000
    reset = 1'b1;
    @(negedge clk);
    check("C_busy_before_rst", fill_busy, 1);
    check("C_rst_no_grant",    vram_load, 0);
    check("C_rst_addr",        vram_addr, 9);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("C_abort_busy", fill_busy, 0);
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      if (fill_done) pulses++;
      tick();
      @(negedge clk);
    end
    check("C_no_done", pulses, 0);

    // ---------------- fill D: restart from word 0 ----------------
    clr_mem      = 1'b1;
    fill_start   = 1'b1;
    fill_pattern = 16'h1111;
    tick();
    clr_mem    = 1'b0;
    fill_start = 1'b0;
    done_n = 0;
    for (int n = 1; n <= 9000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("D_first_addr", vram_addr, 0);
        check("D_first_din",  vram_din,  16'h1111);
      end
      if (fill_done) begin
        done_n = n;
        break;
      end
      tick();
    end
    check("D_duration", done_n, 8193);
    check("D_mem", count_bad(16'h1111, -1, 16'h0, 0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
